snoop_bus_ctrl: RTL and testbench

//  Arbitrates the shared snoop bus among N_REQ cache controllers and sequences each coherence

---
 rtl/snoop_bus_ctrl_pkg.sv | 35 +++
 rtl/snoop_bus_ctrl_rr_arbiter.sv | 38 +++
 rtl/snoop_bus_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared definitions for the snoop bus controller and the cache directories.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Optional feature macro: SNOOP_HIT_FWD_EN adds the cache-to-cache forward state S_FWD.
package snoop_bus_ctrl_pkg;

  // Address split shared with the cache directory: 16-bit tag + 8-bit index.
  localparam int TAG_W      = 16;
  localparam int IDX_W      = 8;
  localparam int BUS_ADDR_W = TAG_W + IDX_W;

  // Line state encoding carried on STATUS replies and fill_status.
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SNOOP = 3'd1,
    S_RESP  = 3'd2,
    S_WB    = 3'd3,
    S_MEM   = 3'd4,
    S_DONE  = 3'd5
`ifdef SNOOP_HIT_FWD_EN
    ,S_FWD  = 3'd6
`endif
  } bus_state_e;

  // Writes always end Modified; reads end Shared if any other cache holds the line.
  function automatic logic [1:0] fill_state(input logic rw, input logic hit_shared);
    return rw ? ST_M : (hit_shared ? ST_S : ST_E);
  endfunction

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr_i, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is taken and advances the pointer.
// Ports: req_i request vector, ptr_i search start, gnt_o one-hot grant, gnt_idx_o index,
//        vld_o any grant, nxt_ptr_o pointer to use after this grant (winner + 1 mod N_REQ).
module snoop_bus_ctrl_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
  output logic                     vld_o,
  output logic [$clog2(N_REQ)-1:0] nxt_ptr_o
);

  localparam int PTR_W = $clog2(N_REQ);

  int cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    nxt_ptr_o = ptr_i;
    vld_o     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = PTR_W'(cand);
        nxt_ptr_o   = PTR_W'((cand + 1) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snoop bus controller: round-robin bus grant, snoop broadcast, status reduction,
//   optional writeback, memory fill and completion with the requester's fill state.
// Latency: done at cycle 3+MEM_LAT after grant (miss/clean hit), 3+2*MEM_LAT on an M hit
//   (4 on an M hit with SNOOP_HIT_FWD_EN defined). Backpressure: requests wait while busy.
// Ports: sclk_i/srst_i clock and sync active-high reset; req_i/req_rw_i/req_addr_i per-cache
//   request, op and address; snp_status_i per-cache STATUS; grant_o/addr_o/rw_o bus owner,
//   address and op; snoop_o/pinv_o/done_o strobes; mem_rd_o/mem_wb_o memory phases;
//   fill_status_o state to install in the requester, valid with done_o.
// Macro SNOOP_HIT_FWD_EN: an M hit forwards cache-to-cache in one cycle instead of WB + MEM.
module snoop_bus_ctrl
  import snoop_bus_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int MEM_LAT = 4
) (
  input  logic                      sclk_i,
  input  logic                      srst_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          req_rw_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*2-1:0]        snp_status_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic [ADDR_W-1:0]         addr_o,
  output logic                      snoop_o,
  output logic                      rw_o,
  output logic                      pinv_o,
  output logic                      mem_rd_o,
  output logic                      mem_wb_o,
  output logic                      done_o,
  output logic [1:0]                fill_status_o
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  bus_state_e        state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_REQ-1:0]  grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic              snoop_q;
  logic              pinv_q;
  logic              mem_rd_q;
  logic              mem_wb_q;
  logic              done_q;
  logic [1:0]        fill_q;
  logic              hit_shared_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_vld;
  logic [PTR_W-1:0]  arb_nxt;
  logic              any_m;
  logic              any_hit;

  snoop_bus_ctrl_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .vld_o     (arb_vld),
    .nxt_ptr_o (arb_nxt)
  );

  // The requester's own reply is excluded by its grant bit, so X on that slice never
  // reaches the reduction.
  always_comb begin
    any_m   = 1'b0;
    any_hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_q[i]) begin
        if (snp_status_i[2*i +: 2] == ST_M) any_m   = 1'b1;
        if (snp_status_i[2*i +: 2] != ST_I) any_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk_i) begin
    if (srst_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      snoop_q      <= 1'b0;
      pinv_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wb_q     <= 1'b0;
      done_q       <= 1'b0;
      fill_q       <= ST_I;
      hit_shared_q <= 1'b0;
    end else begin
      // Strobes are high for exactly one cycle.
      snoop_q <= 1'b0;
      pinv_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_vld) begin
            grant_q <= arb_gnt;
            addr_q  <= req_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
            rw_q    <= req_rw_i[arb_idx];
            ptr_q   <= arb_nxt;
            snoop_q <= 1'b1;
            state_q <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          pinv_q  <= rw_q;
          state_q <= S_RESP;
        end
        S_RESP: begin
          hit_shared_q <= any_hit;
          cnt_q        <= CNT_LOAD;
          if (any_m) begin
            mem_wb_q <= 1'b1;
`ifdef SNOOP_HIT_FWD_EN
            state_q  <= S_FWD;
`else
            state_q  <= S_WB;
`endif
          end else begin
            mem_rd_q <= 1'b1;
            state_q  <= S_MEM;
          end
        end
        S_WB: begin
          if (cnt_q == '0) begin
            mem_wb_q <= 1'b0;
            mem_rd_q <= 1'b1;
            cnt_q    <= CNT_LOAD;
            state_q  <= S_MEM;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_MEM: begin
          if (cnt_q == '0) begin
            mem_rd_q <= 1'b0;
            done_q   <= 1'b1;
            fill_q   <= fill_state(rw_q, hit_shared_q);
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef SNOOP_HIT_FWD_EN
        S_FWD: begin
          mem_wb_q <= 1'b0;
          done_q   <= 1'b1;
          fill_q   <= fill_state(rw_q, hit_shared_q);
          state_q  <= S_DONE;
        end
`endif
        S_DONE: begin
          grant_q      <= '0;
          addr_q       <= '0;
          rw_q         <= 1'b0;
          fill_q       <= ST_I;
          hit_shared_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign addr_o        = addr_q;
  assign rw_o          = rw_q;
  assign snoop_o       = snoop_q;
  assign pinv_o        = pinv_q;
  assign mem_rd_o      = mem_rd_q;
  assign mem_wb_o      = mem_wb_q;
  assign done_o        = done_q;
  assign fill_status_o = fill_q;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Self-checking bench for snoop_bus_ctrl: directed scenarios followed by random transactions,
//   each cycle compared against a timeline model built from the transaction rules.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_snoop_bus_ctrl;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 24;
  localparam int MEM_LAT = 4;
`ifdef SNOOP_HIT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                    clk;
  logic                    srst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_rw;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*2-1:0]      snp;
  logic [N_REQ-1:0]        grant;
  logic [ADDR_W-1:0]       addr;
  logic                    snoop, rw, pinv, mem_rd, mem_wb, done;
  logic [1:0]              fill;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int tb_ptr  = 0;
  int txn_id  = 0;

  snoop_bus_ctrl #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .sclk_i        (clk),
    .srst_i        (srst),
    .req_i         (req),
    .req_rw_i      (req_rw),
    .req_addr_i    (req_addr),
    .snp_status_i  (snp),
    .grant_o       (grant),
    .addr_o        (addr),
    .snoop_o       (snoop),
    .rw_o          (rw),
    .pinv_o        (pinv),
    .mem_rd_o      (mem_rd),
    .mem_wb_o      (mem_wb),
    .done_o        (done),
    .fill_status_o (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of run, required end before time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed view: {grant, snoop, pinv, mem_wb, mem_rd, done, fill, rw, addr}
  function automatic logic [35:0] obs();
    return {grant, snoop, pinv, mem_wb, mem_rd, done, fill, rw, addr};
  endfunction

  task automatic chk(input string tag, input logic [35:0] o, input logic [35:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, o, e);
    end
  endtask

  // Expected outputs n cycles after the grant decision, from the phase lengths alone.
  function automatic logic [35:0] exp_at(input int n, input int w, input logic r,
                                         input logic [23:0] a, input logic any_m,
                                         input logic hit);
    int wb_s, wb_e, rd_s, rd_e, dn;
    logic [3:0]  g;
    logic [1:0]  f;
    logic [23:0] ea;
    logic        er;
    g = '0; f = 2'b00; ea = '0; er = 1'b0;
    if (FWD && any_m) begin
      wb_s = 3; wb_e = 4; rd_s = 0; rd_e = 0; dn = 4;
    end else begin
      wb_s = 3; wb_e = any_m ? 3 + MEM_LAT : 3;
      rd_s = wb_e; rd_e = rd_s + MEM_LAT; dn = rd_e;
    end
    if (n >= 1 && n <= dn) begin
      g[w] = 1'b1; ea = a; er = r;
    end
    if (n == dn) f = r ? 2'b11 : (hit ? 2'b01 : 2'b10);
    return {g, (n == 1), (n == 2 && r), (n >= wb_s && n < wb_e), (n >= rd_s && n < rd_e),
            (n == dn), f, er, ea};
  endfunction

  // Runs one transaction from an IDLE cycle; drop_n clears req after that cycle's sample,
  // stop_n > 0 abandons the run after that cycle.
  task automatic run_txn(input logic [3:0] rq, input logic [3:0] rwv, input logic [7:0] rp,
                         input int drop_n, input int stop_n);
    int w, dn;
    logic any_m, hit, r;
    logic [23:0] a;
    logic [7:0] drv;
    w = 0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (rq[(tb_ptr + k) % N_REQ]) w = (tb_ptr + k) % N_REQ;
    tb_ptr = (w + 1) % N_REQ;
    req_addr = {$urandom, $urandom, $urandom};
    a = req_addr[w*ADDR_W +: ADDR_W];
    r = rwv[w];
    any_m = 1'b0; hit = 1'b0; drv = rp;
    for (int i = 0; i < N_REQ; i++) begin
      if (i != w) begin
        if (rp[2*i +: 2] == 2'b11) any_m = 1'b1;
        if (rp[2*i +: 2] != 2'b00) hit = 1'b1;
      end
    end
    drv[2*w +: 2] = 2'bxx;
    req = rq; req_rw = rwv; snp = drv;
    dn = (FWD && any_m) ? 4 : 3 + MEM_LAT + (any_m ? MEM_LAT : 0);
    for (int n = 1; n <= dn + 1; n++) begin
      if (stop_n > 0 && n > stop_n) break;
      step();
      chk($sformatf("txn%0d_req%0d_cyc%0d", txn_id, w, n), obs(), exp_at(n, w, r, a, any_m, hit));
      if (n == drop_n) req = '0;
    end
    txn_id++;
  endtask

  initial begin
    srst = 1'b1; req = '0; req_rw = '0; req_addr = '0; snp = '0;
    // 1: reset, then a plain read miss from requester 0.
    step(); step();
    chk("reset_outputs", obs(), 36'h0);
    srst = 1'b0; tb_ptr = 0;
    run_txn(4'b0001, 4'b0000, 8'h00, 0, 0);

    // 2: round-robin with all requests held, starting from a fresh reset.
    srst = 1'b1; req = '0;
    step(); step();
    chk("reset_again", obs(), 36'h0);
    srst = 1'b0; tb_ptr = 0;
    for (int t = 0; t < 5; t++) run_txn(4'b1111, 4'b0000, 8'h00, 0, 0);

    // 3: shared read, cache 2 replies S.
    run_txn(4'b0010, 4'b0000, 8'b00_01_00_00, 0, 0);

    // 4: write from requester 0 with cache 3 holding the line Modified.
    run_txn(4'b0001, 4'b0001, 8'b11_00_00_00, 0, 0);

    // 5: reset during the memory phase, then requester 2 wins from pointer 0.
    run_txn(4'b1100, 4'b0000, 8'h00, 0, 4);
    srst = 1'b1;
    step();
    chk("reset_in_mem", obs(), 36'h0);
    srst = 1'b0; tb_ptr = 0;
    run_txn(4'b1100, 4'b0000, 8'h00, 0, 0);
    run_txn(4'b1100, 4'b0100, 8'b00_00_01_10, 0, 0);

    // 6: requester drops req during RESP; the transaction still completes, no regrant.
    run_txn(4'b1000, 4'b0000, 8'b00_00_11_00, 2, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("no_regrant_%0d", k), obs(), 36'h0);
    end

    // Random transactions.
    for (int t = 0; t < 40; t++) begin
      run_txn(4'($urandom_range(1, 15)), 4'($urandom), 8'($urandom), 0, 0);
    end
    req = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
